// File: rtl/dbi_rx_decoder_if.sv
// Bus interface for dbi_rx_decoder.
// Beat side (PHY -> decoder): rx_valid, rx_first, rx_dq[DW], rx_dbi_n.
// Burst side (decoder -> core): out_valid, out_ready, out_data[DW*BL],
//   out_inv[BL], out_viol.
// slave  = decoder view, master = PHY/core (testbench) view.
interface dbi_rx_decoder_if #(
  parameter int DW = 8,
  parameter int BL = 8
);
  logic              rx_valid;
  logic              rx_first;
  logic [DW-1:0]     rx_dq;
  logic              rx_dbi_n;
  logic              out_valid;
  logic              out_ready;
  logic [DW*BL-1:0]  out_data;
  logic [BL-1:0]     out_inv;
  logic              out_viol;

  modport slave (
    input  rx_valid, rx_first, rx_dq, rx_dbi_n, out_ready,
    output out_valid, out_data, out_inv, out_viol
  );

  modport master (
    output rx_valid, rx_first, rx_dq, rx_dbi_n, out_ready,
    input  out_valid, out_data, out_inv, out_viol
  );
endinterface

// File: rtl/dbi_rx_decoder.sv
// Receive-side DBI decoder for one byte lane.
// Decodes DBI-encoded beats, assembles BL-beat bursts, checks the DC-DBI
// rule per beat, and hands completed bursts to the core through a 2-entry
// valid/ready buffer.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   dbi_en      - decode enable, latched on the first beat of each burst
//   bus         - beat input and burst output (dbi_rx_decoder_if.slave)
//   frame_err   - one-cycle pulse on a framing error
//   overflow    - sticky, a completed burst was dropped (buffer full)
//   viol_cnt    - saturating count of beats violating the DBI rule
module dbi_rx_decoder #(
  parameter int DW   = 8,
  parameter int BL   = 8,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dbi_en,
  dbi_rx_decoder_if.slave      bus,
  output logic                 frame_err,
  output logic                 overflow,
  output logic [CNTW-1:0]      viol_cnt
);
  localparam int CW = $clog2(BL);
  localparam int ZW = $clog2(DW + 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  typedef struct packed {
    logic [DW*BL-1:0] data;
    logic [BL-1:0]    inv;
    logic             viol;
  } entry_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  beat_cnt;
  logic           en_lat;
  logic           start, store, last, fe_nxt;
  logic           beat_en;
  logic [DW-1:0]  beat_data;
  logic           beat_inv, beat_viol;
  logic [ZW-1:0]  zeros;

  logic [DW*BL-1:0] asm_data;
  logic [BL-1:0]    asm_inv;
  logic             asm_viol;
  logic             push_pend;

  entry_t         mem [2];
  logic           wr_ptr, rd_ptr;
  logic [1:0]     count;
  logic           pop, push_ok, drop;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    store     = 1'b0;
    fe_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          if (bus.rx_first) begin
            start     = 1'b1;
            state_nxt = COLLECT;
          end else begin
            fe_nxt = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (bus.rx_valid) begin
          if (bus.rx_first) begin
            // Restart: partial burst is abandoned, this beat becomes beat 0.
            start  = 1'b1;
            fe_nxt = 1'b1;
          end else begin
            store = 1'b1;
            if (beat_cnt == CW'(BL - 1)) state_nxt = IDLE;
          end
        end
      end
    endcase
  end

  assign last = store && (beat_cnt == CW'(BL - 1));

  // The enable for beat 0 comes straight from dbi_en; later beats use the latch.
  assign beat_en = start ? dbi_en : en_lat;

  always_comb begin
    zeros = '0;
    for (int unsigned i = 0; i < DW; i++)
      zeros = zeros + {{(ZW-1){1'b0}}, ~bus.rx_dq[i]};
  end

  always_comb begin
    if (beat_en) begin
      beat_data = bus.rx_dbi_n ? bus.rx_dq : ~bus.rx_dq;
      beat_inv  = ~bus.rx_dbi_n;
      beat_viol = (zeros > ZW'(DW / 2));
    end else begin
      beat_data = bus.rx_dq;
      beat_inv  = 1'b0;
      beat_viol = ~bus.rx_dbi_n;
    end
  end

  // Assembly: the completed burst is held registered and pushed on the
  // following edge, so no rx_* input reaches the buffer combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      en_lat    <= 1'b0;
      asm_data  <= '0;
      asm_inv   <= '0;
      asm_viol  <= 1'b0;
      push_pend <= 1'b0;
      frame_err <= 1'b0;
      viol_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      push_pend <= last;
      frame_err <= fe_nxt;
      if (start) begin
        en_lat           <= dbi_en;
        asm_data[DW-1:0] <= beat_data;
        asm_inv          <= BL'(beat_inv);
        asm_viol         <= beat_viol;
        beat_cnt         <= CW'(1);
      end else if (store) begin
        asm_data[beat_cnt*DW +: DW] <= beat_data;
        asm_inv[beat_cnt]           <= beat_inv;
        asm_viol                    <= asm_viol | beat_viol;
        beat_cnt                    <= last ? '0 : beat_cnt + 1'b1;
      end
      if ((start || store) && beat_viol && (viol_cnt != '1))
        viol_cnt <= viol_cnt + 1'b1;
    end
  end

  assign pop     = (count != 2'd0) && bus.out_ready;
  assign push_ok = push_pend && ((count != 2'd2) || pop);
  assign drop    = push_pend && (count == 2'd2) && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= '{data: asm_data, inv: asm_inv, viol: asm_viol};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = mem[rd_ptr].data;
  assign bus.out_inv   = mem[rd_ptr].inv;
  assign bus.out_viol  = mem[rd_ptr].viol;
endmodule

// File: tb/tb_dbi_rx_decoder.sv
// Self-checking bench for dbi_rx_decoder: directed bursts, expected bursts
// queued at drive time and compared when the decoder presents them.
module tb_dbi_rx_decoder;
  localparam int DW   = 8;
  localparam int BL   = 8;
  localparam int CNTW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            dbi_en = 1'b0;
  logic            frame_err;
  logic            overflow;
  logic [CNTW-1:0] viol_cnt;

  dbi_rx_decoder_if #(.DW(DW), .BL(BL)) bus ();

  dbi_rx_decoder #(.DW(DW), .BL(BL), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dbi_en    (dbi_en),
    .bus       (bus),
    .frame_err (frame_err),
    .overflow  (overflow),
    .viol_cnt  (viol_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW*BL-1:0] data;
    logic [BL-1:0]    inv;
    logic             viol;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               n_cmp = 0;
  int               n_bad = 0;
  int               exp_vc = 0;
  logic             cur_en = 1'b0;
  logic [DW*BL-1:0] acc_d = '0;
  logic [BL-1:0]    acc_i = '0;
  logic             acc_v = 1'b0;
  logic [DW*BL-1:0] head_d;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int zc(input logic [DW-1:0] v);
    int n = 0;
    for (int i = 0; i < DW; i++) if (!v[i]) n++;
    return n;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rx_valid = 1'b0;
    bus.rx_first = 1'b0;
    cyc();
  endtask

  // One beat, with the reference decode folded into the running burst.
  task automatic drive_beat(input logic first, input logic [DW-1:0] dq,
                            input logic dbin, input int idx);
    logic [DW-1:0] d;
    logic          iv, v;
    if (first) begin
      cur_en = dbi_en;
      acc_i  = '0;
      acc_v  = 1'b0;
    end
    bus.rx_valid = 1'b1;
    bus.rx_first = first;
    bus.rx_dq    = dq;
    bus.rx_dbi_n = dbin;
    d  = cur_en ? (dbin ? dq : ~dq) : dq;
    iv = cur_en & ~dbin;
    v  = cur_en ? (zc(dq) > DW / 2) : ~dbin;
    if (v) exp_vc++;
    acc_d[idx*DW +: DW] = d;
    acc_i[idx]          = iv;
    acc_v               = acc_v | v;
    cyc();
  endtask

  task automatic send_burst(input logic en, input logic [DW*BL-1:0] dq,
                            input logic [BL-1:0] dbin, input logic keep,
                            input logic fe0);
    dbi_en = en;
    for (int k = 0; k < BL; k++) begin
      drive_beat(k == 0, dq[k*DW +: DW], dbin[k], k);
      check("frame_err", 64'(frame_err), (k == 0) ? 64'(fe0) : 64'd0);
    end
    if (keep) sb.push_back('{data: acc_d, inv: acc_i, viol: acc_v});
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) cyc();
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check("burst_expected", 64'(bus.out_valid), 64'(sb.size() != 0));
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("out_data", bus.out_data, mon_e.data);
        check("out_inv", 64'(bus.out_inv), 64'(mon_e.inv));
        check("out_viol", 64'(bus.out_viol), 64'(mon_e.viol));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_first  = 1'b0;
    bus.rx_dq     = '0;
    bus.rx_dbi_n  = 1'b1;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_inv", 64'(bus.out_inv), 64'd0);
    check("rst_out_viol", 64'(bus.out_viol), 64'd0);
    check("rst_frame_err", 64'(frame_err), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_viol_cnt", 64'(viol_cnt), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Clean burst: 0x00,0xFF,... sent as all-0xFF with alternating DBI.
    send_burst(1'b1, {BL{8'hFF}}, 8'hAA, 1'b1, 1'b0);
    check("latency_pre", 64'(bus.out_valid), 64'd0);
    idle();
    check("latency_post", 64'(bus.out_valid), 64'd1);
    check("clean_data_lo", 64'(bus.out_data[15:0]), 64'h0000_0000_0000_FF00);
    check("clean_inv", 64'(bus.out_inv), 64'h55);
    check("clean_viol", 64'(bus.out_viol), 64'd0);
    bus.out_ready = 1'b1;
    drain();

    // Violations: 7 and 5 zeros violate, exactly DW/2 does not; enable off
    // flags only an inverted beat.
    send_burst(1'b1, 64'hFFFF_FFFF_FF07_0F01, 8'hFF, 1'b1, 1'b0);
    send_burst(1'b0, 64'h5A5A_5A5A_5A5A_0001, 8'hFE, 1'b1, 1'b0);
    idle();
    drain();
    check("viol_cnt_a", 64'(viol_cnt), 64'(exp_vc));
    check("viol_cnt_lit", 64'(viol_cnt), 64'd3);

    // Framing: rx_first on beat 3 restarts the burst.
    dbi_en = 1'b1;
    drive_beat(1'b1, 8'hFF, 1'b1, 0);
    drive_beat(1'b0, 8'hF0, 1'b1, 1);
    drive_beat(1'b0, 8'hFF, 1'b0, 2);
    check("fe_partial", 64'(frame_err), 64'd0);
    send_burst(1'b1, 64'h0123_4567_89AB_CDEF, 8'hF0, 1'b1, 1'b1);
    idle();
    drain();
    // Stray beat in IDLE.
    bus.rx_valid = 1'b1;
    bus.rx_first = 1'b0;
    bus.rx_dq    = 8'hFF;
    bus.rx_dbi_n = 1'b1;
    cyc();
    check("fe_stray", 64'(frame_err), 64'd1);
    idle();
    check("fe_stray_end", 64'(frame_err), 64'd0);
    idle();
    check("stray_no_out", 64'(bus.out_valid), 64'd0);
    check("viol_cnt_b", 64'(viol_cnt), 64'(exp_vc));

    // Backpressure: three bursts, third dropped.
    bus.out_ready = 1'b0;
    send_burst(1'b1, 64'h0F1E_2D3C_4B5A_6978, 8'hA5, 1'b1, 1'b0);
    send_burst(1'b0, 64'h8877_6655_4433_2211, 8'hFF, 1'b1, 1'b0);
    send_burst(1'b0, 64'hDEAD_BEEF_CAFE_F00D, 8'h7F, 1'b0, 1'b0);
    check("ovf_before", 64'(overflow), 64'd0);
    idle();
    check("ovf_set", 64'(overflow), 64'd1);
    head_d = sb[0].data;
    check("hold_head", bus.out_data, head_d);
    idle();
    idle();
    check("hold_stable", bus.out_data, head_d);
    check("viol_cnt_drop", 64'(viol_cnt), 64'(exp_vc));
    bus.out_ready = 1'b1;
    drain();
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Reset mid-burst with a burst parked in the buffer.
    bus.out_ready = 1'b0;
    send_burst(1'b1, 64'h1234_5678_9ABC_DEF0, 8'h3C, 1'b0, 1'b0);
    idle();
    dbi_en = 1'b1;
    drive_beat(1'b1, 8'hFF, 1'b1, 0);
    drive_beat(1'b0, 8'h01, 1'b1, 1);
    drive_beat(1'b0, 8'hFF, 1'b0, 2);
    drive_beat(1'b0, 8'hFF, 1'b1, 3);
    check("viol_cnt_pre_rst", 64'(viol_cnt), 64'(exp_vc));
    #2;
    rst_n = 1'b0;
    #1;
    exp_vc = 0;
    check("mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_out_data", bus.out_data, 64'd0);
    check("mid_out_inv", 64'(bus.out_inv), 64'd0);
    check("mid_out_viol", 64'(bus.out_viol), 64'd0);
    check("mid_overflow", 64'(overflow), 64'd0);
    check("mid_viol_cnt", 64'(viol_cnt), 64'd0);
    bus.rx_valid = 1'b0;
    bus.rx_first = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
    bus.out_ready = 1'b1;
    send_burst(1'b1, 64'h00FF_0180_7E3C_A55A, 8'h96, 1'b1, 1'b0);
    idle();
    drain();
    check("viol_cnt_restart", 64'(viol_cnt), 64'(exp_vc));

    // Simultaneous push and pop while full.
    bus.out_ready = 1'b0;
    send_burst(1'b1, 64'h1111_2222_3333_4444, 8'h0F, 1'b1, 1'b0);
    send_burst(1'b0, 64'h5555_6666_7777_8888, 8'hFF, 1'b1, 1'b0);
    send_burst(1'b1, 64'h9999_AAAA_BBBB_CCCC, 8'hC3, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    idle();
    check("simul_no_ovf", 64'(overflow), 64'd0);
    drain();
    check("simul_ovf_end", 64'(overflow), 64'd0);
    check("viol_cnt_end", 64'(viol_cnt), 64'(exp_vc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
